stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, maximum cycles one memory access waits for mem_ready; used only with STACK_CTRL_TIMEOUT_EN.
REQ-002 clock  input  1  single block clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_start  input  1  request to start a stack operation.
REQ-005 op_pop  input  1  operation select: 0 = PUSH, 1 = POP; sampled with op_start.
REQ-006 push_data  input  16  word to push; sampled with op_start.
REQ-007 sp  input  16  current stack pointer from the SP register block.
REQ-008 mem_rdata  input  8  memory read data; valid when mem_ready=1 during a read.
REQ-009 mem_ready  input  1  memory access complete this cycle.
REQ-010 sp_sel  output  3  SP register update select: 0 hold, 1 increment, 2 decrement.
REQ-011 mem_addr  output  16  byte address of the current access.
REQ-012 mem_wdata  output  8  write data.
REQ-013 mem_rd  output  1  read strobe; held until mem_ready.
REQ-014 mem_wr  output  1  write strobe; held until mem_ready.
REQ-015 busy  output  1  operation in progress.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 pop_data  output  16  word read by the last completed POP.
REQ-018 fault  output  1  valid with done; operation aborted on timeout.

Function
REQ-019 FSM states SHALL be IDLE, DEC1, WR_HI, DEC2, WR_LO, RD_LO, INC1, RD_HI, INC2 and DONE.
REQ-020 In IDLE, op_start=1 SHALL latch op_pop and push_data and move to DEC1 (PUSH) or RD_LO (POP). op_start outside IDLE SHALL be ignored.
REQ-021 PUSH sequence: DEC1 -> WR_HI -> DEC2 -> WR_LO -> DONE. POP sequence: RD_LO -> INC1 -> RD_HI -> INC2 -> DONE. DONE -> IDLE.
REQ-022 sp_sel SHALL be 2 in DEC1 and DEC2, 1 in INC1 and INC2, and 0 in every other state. Each of these states SHALL last exactly 1 cycle.
REQ-023 In WR_HI, WR_LO, RD_LO and RD_HI, mem_addr SHALL equal sp. In all other states mem_addr SHALL be 0.
REQ-024 WR_HI SHALL drive mem_wr=1 and mem_wdata=push_data[15:8]. WR_LO SHALL drive mem_wr=1 and mem_wdata=push_data[7:0]. Outside these two states mem_wdata SHALL be 0.
REQ-025 RD_LO and RD_HI SHALL drive mem_rd=1. On mem_ready, mem_rdata SHALL be captured into pop_data[7:0] or pop_data[15:8] respectively.
REQ-026 Access states SHALL advance only on mem_ready=1; mem_ready in any other state SHALL be ignored.
REQ-027 Zero-wait latency: done SHALL rise 5 cycles after the accepting edge, for both PUSH and POP.
REQ-028 busy SHALL be 1 in every state except IDLE, including DONE.
REQ-029 SP arithmetic wraps: 0x0000 decremented gives 0xFFFF, and 0xFFFF incremented gives 0x0000. No error is flagged.
REQ-030 pop_data SHALL hold its value until the next POP capture; a PUSH SHALL NOT alter it.

Reset
REQ-031 When reset=1 at a clock edge, the next state SHALL be IDLE, pop_data SHALL be 0, and all latched operands and counters SHALL be 0.
REQ-032 While in IDLE after reset, outputs SHALL be: sp_sel=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0, busy=0, done=0, fault=0.
REQ-033 Reset in mid-operation SHALL abandon the operation with no done pulse. Any SP change already made SHALL stand.

Configuration
REQ-034 With STACK_CTRL_TIMEOUT_EN defined, a per-access counter SHALL clear on entry to each access state.
REQ-035 When that counter reaches MEM_TIMEOUT without mem_ready, the FSM SHALL deassert strobes and go to DONE with fault=1. Remaining steps SHALL be skipped and pop_data SHALL keep any bytes already captured.
REQ-036 Without STACK_CTRL_TIMEOUT_EN, access states SHALL wait indefinitely, fault SHALL be constant 0, and no counter logic SHALL exist.

Structure
REQ-037 Shared package stack_ctrl_pkg SHALL hold: the state enumeration; the sp_sel encodings (hold 0, incr 1, decr 2, temp_buf 3, data_bus_rel 4), matching the SP register block; and the op_pop encodings.
REQ-038 The design SHALL have no sub-modules; the timeout counter SHALL be inline and guarded by the macro.

Verification
REQ-039 sp=0xFFFE, PUSH 0x1234, mem_ready tied 1 -> write 0x12 @0xFFFD, then 0x34 @0xFFFC; done 5 cycles after accept.
REQ-040 sp=0xFFFC, POP, rdata 0x34 then 0x12, mem_ready=1 -> reads @0xFFFC and @0xFFFD; sp_sel=1 twice; pop_data=0x1234 at done.
REQ-041 PUSH with mem_ready low 3 cycles in WR_HI -> mem_wr and mem_addr held stable; done at accept+8.
REQ-042 op_start pulsed while busy -> ignored; exactly one done pulse.
REQ-043 Reset asserted during RD_HI -> IDLE next cycle; no done pulse; pop_data=0.
REQ-044 STACK_CTRL_TIMEOUT_EN defined, mem_ready held 0 in WR_HI -> strobe drops after 15 cycles; done=1 and fault=1 together for one cycle.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack controller: FSM states, SP-select codes
// (matching the SP register block) and the PUSH/POP operation select.
package stack_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DEC1,
      S_WR_HI,
      S_DEC2,
      S_WR_LO,
      S_RD_LO,
      S_INC1,
      S_RD_HI,
      S_INC2,
      S_DONE
   } state_e;

   localparam logic [2:0] SP_HOLD         = 3'd0;
   localparam logic [2:0] SP_INCR         = 3'd1;
   localparam logic [2:0] SP_DECR         = 3'd2;
   localparam logic [2:0] SP_TEMP_BUF     = 3'd3;
   localparam logic [2:0] SP_DATA_BUS_REL = 3'd4;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   function automatic logic is_access(state_e s);
      return s inside {S_WR_HI, S_WR_LO, S_RD_LO, S_RD_HI};
   endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Operation request, SP register and byte-memory signals of the stack
// controller; master = requester/SP block/memory, slave = controller.
interface stack_ctrl_if;
   import stack_ctrl_pkg::*;

   logic        op_start;
   logic        op_pop;
   logic [15:0] push_data;
   logic [15:0] sp;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic [2:0]  sp_sel;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic        busy;
   logic        done;
   logic [15:0] pop_data;
   logic        fault;

   modport master (
      output op_start, op_pop, push_data, sp, mem_rdata, mem_ready,
      input  sp_sel, mem_addr, mem_wdata, mem_rd, mem_wr,
      input  busy, done, pop_data, fault
   );

   modport slave (
      input  op_start, op_pop, push_data, sp, mem_rdata, mem_ready,
      output sp_sel, mem_addr, mem_wdata, mem_rd, mem_wr,
      output busy, done, pop_data, fault
   );

endinterface

// File: rtl/stack_ctrl.sv
// 16-bit PUSH/POP sequencer over an 8-bit memory and an external SP block.
// STACK_CTRL_TIMEOUT_EN adds a per-access mem_ready timeout with fault.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input logic         clock,
   input logic         reset,
   stack_ctrl_if.slave bus
);

   state_e      state_q, state_d;
   logic [15:0] data_q, data_d;
   logic [15:0] pop_q, pop_d;
   logic        acc;
   logic        tmo;

   assign acc = is_access(state_q);

`ifdef STACK_CTRL_TIMEOUT_EN
   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          fault_q, fault_d;

   // Counter restarts on every entry since access states are never adjacent.
   assign cnt_d   = acc ? cnt_q + CW'(1) : '0;
   assign tmo     = acc && !bus.mem_ready && (cnt_q == CW'(MEM_TIMEOUT - 1));
   assign fault_d = tmo;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign bus.fault = fault_q;
`else
   logic unused_timeout;

   assign tmo            = 1'b0;
   assign unused_timeout = ^MEM_TIMEOUT;
   assign bus.fault      = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         pop_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         pop_q   <= pop_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      pop_d         = pop_q;
      bus.sp_sel    = SP_HOLD;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.op_start) begin
               data_d  = bus.push_data;
               state_d = (bus.op_pop == OP_POP) ? S_RD_LO : S_DEC1;
            end
         end
         S_DEC1: begin
            bus.sp_sel = SP_DECR;
            state_d    = S_WR_HI;
         end
         S_WR_HI: begin
            bus.mem_addr  = bus.sp;
            bus.mem_wr    = 1'b1;
            bus.mem_wdata = data_q[15:8];
            if (bus.mem_ready) state_d = S_DEC2;
         end
         S_DEC2: begin
            bus.sp_sel = SP_DECR;
            state_d    = S_WR_LO;
         end
         S_WR_LO: begin
            bus.mem_addr  = bus.sp;
            bus.mem_wr    = 1'b1;
            bus.mem_wdata = data_q[7:0];
            if (bus.mem_ready) state_d = S_DONE;
         end
         S_RD_LO: begin
            bus.mem_addr = bus.sp;
            bus.mem_rd   = 1'b1;
            if (bus.mem_ready) begin
               pop_d[7:0] = bus.mem_rdata;
               state_d    = S_INC1;
            end
         end
         S_INC1: begin
            bus.sp_sel = SP_INCR;
            state_d    = S_RD_HI;
         end
         S_RD_HI: begin
            bus.mem_addr = bus.sp;
            bus.mem_rd   = 1'b1;
            if (bus.mem_ready) begin
               pop_d[15:8] = bus.mem_rdata;
               state_d     = S_INC2;
            end
         end
         S_INC2: begin
            bus.sp_sel = SP_INCR;
            state_d    = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (tmo) state_d = S_DONE;
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.pop_data = pop_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: vector table, hand-written corner
// sequences and random PUSH/POP traffic against a byte-stack model.
module tb_stack_ctrl;
   import stack_ctrl_pkg::*;

   typedef struct packed {
      logic        wr;
      logic [15:0] a;
      logic [7:0]  d;
   } acc_t;

   typedef struct {
      bit          pop;
      logic [15:0] sp;
      logic [15:0] data;
      int          st0;
      int          st1;
      bit          noise;
      int          exp_done;
      logic [15:0] exp_pd;
      logic [15:0] exp_sp;
   } vec_t;

   bit          clock = 1'b0;
   bit          reset = 1'b1;
   int          checks = 0;
   int          errors = 0;

   logic        sp_ld = 1'b1;
   logic [15:0] sp_ld_v = 16'h0000;
   logic [15:0] sp_m;
   logic [15:0] pd_m = 16'h0000;
   logic [7:0]  mem_m [logic [15:0]];

   acc_t        acc_q [$];
   int          n_inc, n_dec, n_stb, bad_idle, bad_hold;

   stack_ctrl_if ifc ();

   stack_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always #5 clock = ~clock;

   // SP register block stand-in, obeying sp_sel.
   always @(posedge clock) begin
      if (sp_ld) sp_m <= sp_ld_v;
      else if (ifc.sp_sel == SP_INCR) sp_m <= sp_m + 16'd1;
      else if (ifc.sp_sel == SP_DECR) sp_m <= sp_m - 16'd1;
   end

   assign ifc.sp = sp_m;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] rdb(input logic [15:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return a[7:0] ^ 8'hA5;
   endfunction

   task automatic load_sp(input logic [15:0] v);
      sp_ld   = 1'b1;
      sp_ld_v = v;
      step();
      sp_ld   = 1'b0;
   endtask

   task automatic run_op(input bit pop, input logic [15:0] d,
                         input int st0, input int st1, input bit noise,
                         output int dcyc, output int ndone, output bit flt);
      int          left, cyc;
      bit          pstall;
      logic [15:0] paddr;
      logic [7:0]  pdat;
      acc_q.delete();
      n_inc = 0; n_dec = 0; n_stb = 0; bad_idle = 0; bad_hold = 0;
      ifc.op_start  = 1'b1;
      ifc.op_pop    = pop;
      ifc.push_data = d;
      ifc.mem_ready = 1'b0;
      step();
      ifc.op_start  = 1'b0;
      ifc.op_pop    = 1'($urandom);
      ifc.push_data = 16'($urandom);
      left = st0; cyc = 0; dcyc = -1; ndone = 0; flt = 1'b0;
      pstall = 1'b0; paddr = '0; pdat = '0;
      while (cyc < 200 && (dcyc < 0 || cyc < dcyc + 3)) begin
         cyc++;
         if (ifc.sp_sel == SP_INCR) n_inc++;
         if (ifc.sp_sel == SP_DECR) n_dec++;
         if (ifc.done) begin
            ndone++;
            if (dcyc < 0) begin
               dcyc = cyc;
               flt  = ifc.fault;
            end
         end
         if (ifc.mem_rd || ifc.mem_wr) begin
            n_stb++;
            if (pstall && (ifc.mem_addr !== paddr || ifc.mem_wdata !== pdat))
               bad_hold++;
            paddr = ifc.mem_addr;
            pdat  = ifc.mem_wdata;
            ifc.mem_ready = (left == 0);
            ifc.mem_rdata = ifc.mem_rd ? rdb(ifc.mem_addr) : 8'($urandom);
            pstall = !ifc.mem_ready;
            if (ifc.mem_ready) begin
               acc_q.push_back({ifc.mem_wr, ifc.mem_addr,
                                ifc.mem_wr ? ifc.mem_wdata : ifc.mem_rdata});
               left = st1;
            end else begin
               left--;
            end
         end else begin
            if (ifc.mem_addr !== 16'h0 || ifc.mem_wdata !== 8'h0) bad_idle++;
            ifc.mem_ready = 1'($urandom);
            ifc.mem_rdata = 8'($urandom);
            pstall = 1'b0;
         end
         ifc.op_start = noise && ifc.busy;
         ifc.op_pop   = 1'($urandom);
         step();
      end
      ifc.op_start  = 1'b0;
      ifc.mem_ready = 1'b0;
   endtask

   task automatic do_op(input string tag, input bit pop, input logic [15:0] d,
                        input int st0, input int st1, input bit noise,
                        input int exp_done, input logic [15:0] exp_pd,
                        input logic [15:0] exp_sp);
      int          dc, nd;
      bit          fl;
      logic [15:0] sp0;
      acc_t        e0, e1;
      sp0   = sp_m;
      e0.wr = !pop;
      e0.a  = pop ? sp0 : sp0 - 16'd1;
      e0.d  = pop ? rdb(sp0) : d[15:8];
      e1.wr = !pop;
      e1.a  = pop ? sp0 + 16'd1 : sp0 - 16'd2;
      e1.d  = pop ? rdb(sp0 + 16'd1) : d[7:0];
      run_op(pop, d, st0, st1, noise, dc, nd, fl);
      if (pop) pd_m = {e1.d, e0.d};
      else begin
         mem_m[e0.a] = e0.d;
         mem_m[e1.a] = e1.d;
      end
      chk({tag, ".done_cycle"}, dc, exp_done);
      chk({tag, ".done_count"}, nd, 1);
      chk({tag, ".fault"}, fl, 0);
      chk({tag, ".n_access"}, acc_q.size(), 2);
      if (acc_q.size() > 0) chk({tag, ".access0"}, acc_q[0], e0);
      if (acc_q.size() > 1) chk({tag, ".access1"}, acc_q[1], e1);
      chk({tag, ".sp_sel_incr"}, n_inc, pop ? 2 : 0);
      chk({tag, ".sp_sel_decr"}, n_dec, pop ? 0 : 2);
      chk({tag, ".sp_final"}, sp_m, exp_sp);
      chk({tag, ".pop_data"}, ifc.pop_data, exp_pd);
      chk({tag, ".pop_model"}, ifc.pop_data, pd_m);
      chk({tag, ".busy_after"}, ifc.busy, 0);
      chk({tag, ".idle_outputs"}, bad_idle, 0);
      chk({tag, ".hold_stable"}, bad_hold, 0);
   endtask

   vec_t        tbl [6];
   int          nd;
   bit          rp;
   int          s0, s1;
   logic [15:0] rd_d, rexp;
`ifdef STACK_CTRL_TIMEOUT_EN
   int          tdc, tnd;
   bit          tfl;
`endif

   initial begin
      tbl[0] = '{0, 16'hFFFE, 16'h1234, 0, 0, 0, 5, 16'h0000, 16'hFFFC};
      tbl[1] = '{1, 16'hFFFC, 16'h0000, 0, 0, 1, 5, 16'h1234, 16'hFFFE};
      tbl[2] = '{0, 16'h0001, 16'hABCD, 3, 0, 1, 8, 16'h1234, 16'hFFFF};
      tbl[3] = '{1, 16'hFFFF, 16'h0000, 1, 2, 1, 8, 16'hABCD, 16'h0001};
      tbl[4] = '{0, 16'h8000, 16'h00FF, 0, 0, 1, 5, 16'hABCD, 16'h7FFE};
      tbl[5] = '{1, 16'h7FFE, 16'h0000, 2, 0, 0, 7, 16'h00FF, 16'h8000};

      ifc.op_start  = 1'b0;
      ifc.op_pop    = 1'b0;
      ifc.push_data = 16'h0;
      ifc.mem_rdata = 8'h0;
      ifc.mem_ready = 1'b0;
      step();
      step();
      chk("reset.busy", ifc.busy, 0);
      reset = 1'b0;
      sp_ld = 1'b0;
      #1;
      chk("reset.sp_sel", ifc.sp_sel, 0);
      chk("reset.mem_addr", ifc.mem_addr, 0);
      chk("reset.mem_wdata", ifc.mem_wdata, 0);
      chk("reset.mem_rd", ifc.mem_rd, 0);
      chk("reset.mem_wr", ifc.mem_wr, 0);
      chk("reset.busy_idle", ifc.busy, 0);
      chk("reset.done", ifc.done, 0);
      chk("reset.fault", ifc.fault, 0);
      chk("reset.pop_data", ifc.pop_data, 0);

      for (int i = 0; i < 6; i++) begin
         load_sp(tbl[i].sp);
         do_op($sformatf("vec%0d", i), tbl[i].pop, tbl[i].data, tbl[i].st0,
               tbl[i].st1, tbl[i].noise, tbl[i].exp_done, tbl[i].exp_pd,
               tbl[i].exp_sp);
      end

      // Reset while waiting in the high-byte read.
      load_sp(16'h1000);
      mem_m[16'h1000] = 8'h77;
      mem_m[16'h1001] = 8'h66;
      ifc.op_start = 1'b1;
      ifc.op_pop   = 1'b1;
      step();
      ifc.op_start  = 1'b0;
      ifc.mem_ready = 1'b1;
      ifc.mem_rdata = 8'h77;
      chk("rst.rd_lo_strobe", ifc.mem_rd, 1);
      step();
      ifc.mem_ready = 1'b0;
      chk("rst.inc1_sel", ifc.sp_sel, SP_INCR);
      step();
      chk("rst.rd_hi_strobe", ifc.mem_rd, 1);
      chk("rst.rd_hi_addr", ifc.mem_addr, 16'h1001);
      chk("rst.low_byte", ifc.pop_data[7:0], 8'h77);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst.busy", ifc.busy, 0);
      chk("rst.pop_data", ifc.pop_data, 0);
      chk("rst.mem_rd", ifc.mem_rd, 0);
      nd = ifc.done ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ifc.done) nd++;
      end
      chk("rst.no_done", nd, 0);
      chk("rst.sp_kept", sp_m, 16'h1001);
      pd_m = 16'h0000;

      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) load_sp(16'($urandom));
         rp   = 1'($urandom);
         s0   = $urandom_range(0, 4);
         s1   = $urandom_range(0, 4);
         rd_d = 16'($urandom);
         rexp = rp ? {rdb(sp_m + 16'd1), rdb(sp_m)} : pd_m;
         do_op($sformatf("rnd%0d", i), rp, rd_d, s0, s1, 1'($urandom),
               5 + s0 + s1, rexp, rp ? sp_m + 16'd2 : sp_m - 16'd2);
      end

`ifdef STACK_CTRL_TIMEOUT_EN
      load_sp(16'h2000);
      run_op(1'b0, 16'hBEEF, 1000, 0, 1'b0, tdc, tnd, tfl);
      chk("tmo.done_cycle", tdc, 17);
      chk("tmo.done_count", tnd, 1);
      chk("tmo.fault", tfl, 1);
      chk("tmo.strobe_cycles", n_stb, 15);
      chk("tmo.n_access", acc_q.size(), 0);
      chk("tmo.sp_final", sp_m, 16'h1FFF);
      chk("tmo.pop_data", ifc.pop_data, pd_m);
      chk("tmo.hold_stable", bad_hold, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
